muldiv_wb_arb: RTL

MULDIV_WB_ARB -- requirements
Module: muldiv_wb_arb

---
 rtl/muldiv_wb_arb.sv | 103 ++++++++++
 1 files changed

// File: rtl/muldiv_wb_arb.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_wb_arb
// Description : Writeback arbiter for multiply/divide results. Buffers
//               responses in a small FIFO, writes them to the register file
//               whenever the main pipeline leaves the write port free, and
//               keeps a per-register pending-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_wb_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_tag,
    input  logic        pipe_wen,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic        sb_set,
    input  logic [4:0]  sb_tag,
    input  logic        kill,
    input  logic [4:0]  kill_tag,
    output logic [31:0] busy
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    // Entry storage; never reset, validity is tracked by count alone.
    logic [4:0]       tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [31:0]      busy_next;

    // Handshake outputs depend only on registered count (plus pipe_wen for
    // the writeback grant), so in_ready has no path from any input.
    assign in_ready = (count != FULL);
    assign wb_valid = (count != '0) && !pipe_wen;
    assign pop      = wb_valid;
    // Responses to x0 are accepted but dropped: nothing to write back.
    assign push     = in_valid && in_ready && (in_tag != 5'd0);
    assign wb_addr  = tag_mem[head];
    assign wb_data  = data_mem[head];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write accepted entries at the tail slot.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[tail]  <= in_tag;
            data_mem[tail] <= in_data;
        end
    end

    // Scoreboard next state: clears first, then set so a same-bit set wins; x0 never busy.
    always_comb begin
        busy_next = busy;
        if (wb_valid)
            busy_next[wb_addr] = 1'b0;
        if (kill)
            busy_next[kill_tag] = 1'b0;
        if (sb_set)
            busy_next[sb_tag] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock) begin
        if (reset)
            busy <= 32'h0;
        else
            busy <= busy_next;
    end

endmodule
`default_nettype wire
